// File: rtl/alu_sequencer_if.sv
// Command (producer -> sequencer) and response (sequencer -> consumer) channels
// of alu_sequencer, both using valid/ready handshakes.
interface alu_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic [3:0]       cmd_op;
   logic             cmd_use_acc;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_carry_out;

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_use_acc, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_result, rsp_carry_out
   );

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_use_acc, rsp_ready,
      output cmd_ready, rsp_valid, rsp_result, rsp_carry_out
   );
endinterface

// File: rtl/alu_sequencer.sv
// Buffers ALU commands in a FIFO, drives the head onto an external combinational
// ALU, and captures result/carry into a backpressured response register.
module alu_sequencer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   alu_sequencer_if.slave         bus,
   input  logic                   i_acc_clear,
   output logic [WIDTH-1:0]       o_alu_a,
   output logic [WIDTH-1:0]       o_alu_b,
   output logic [3:0]             o_alu_operation,
   input  logic [WIDTH-1:0]       i_alu_result,
   input  logic                   i_alu_carry_out,
   output logic [WIDTH-1:0]       o_acc,
   output logic [$clog2(DEPTH):0] o_fifo_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = 2 * WIDTH + 5;

   // Entry layout: {use_acc, op, b, a}
   logic [EW-1:0]    r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_rsp_valid;
   logic [WIDTH-1:0] r_rsp_result;
   logic             r_rsp_carry;
   logic [WIDTH-1:0] r_acc;

   logic             w_empty;
   logic             w_cmd_ready;
   logic             w_push;
   logic             w_issue;
   logic [EW-1:0]    w_head;

   assign w_empty     = (r_count == '0);
   assign w_cmd_ready = (r_count < CW'(DEPTH));
   assign w_push      = bus.cmd_valid && w_cmd_ready;
   assign w_issue     = !w_empty && (!r_rsp_valid || bus.rsp_ready);
   assign w_head      = r_mem[r_rd_ptr];

   assign bus.cmd_ready     = w_cmd_ready;
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.rsp_result    = r_rsp_result;
   assign bus.rsp_carry_out = r_rsp_carry;
   assign o_acc             = r_acc;
   assign o_fifo_count      = r_count;

   always_comb begin
      o_alu_a         = '0;
      o_alu_b         = '0;
      o_alu_operation = '0;
      if (!w_empty) begin
         o_alu_a         = w_head[EW-1] ? r_acc : w_head[WIDTH-1:0];
         o_alu_b         = w_head[2*WIDTH-1:WIDTH];
         o_alu_operation = w_head[2*WIDTH+3:2*WIDTH];
      end
   end

   // Storage is not reset: occupancy alone defines which entries are live.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {bus.cmd_use_acc, bus.cmd_op, bus.cmd_b, bus.cmd_a};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_carry  <= 1'b0;
         r_acc        <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_issue) begin
            r_rd_ptr     <= r_rd_ptr + 1'b1;
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= i_alu_result;
            r_rsp_carry  <= i_alu_carry_out;
         end else if (r_rsp_valid && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
         r_count <= r_count + CW'(w_push) - CW'(w_issue);
         // Clear wins over the issue update; the issuing command already saw the old acc.
         if (i_acc_clear) begin
            r_acc <= '0;
         end else if (w_issue) begin
            r_acc <= i_alu_result;
         end
      end
   end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Command-side driver for the team's 8-bit combinational ALU.
- Accepts operation commands from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command per cycle to the ALU's a/b/operation inputs and registers result/carry_out into a response register with valid/ready backpressure.
- Keeps an accumulator so chained operations can use the previous result as operand a.

Parameters:
WIDTH, 8, operand/result width (matches ALU a, b, result)
DEPTH, 4, command FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  producer has a command
cmd_ready  output  1  FIFO can accept a command
cmd_a  input  WIDTH  operand a (ignored when cmd_use_acc=1)
cmd_b  input  WIDTH  operand b
cmd_op  input  4  ALU operation code, passed through unmodified
cmd_use_acc  input  1  use accumulator as operand a
acc_clear  input  1  synchronous accumulator clear
alu_a  output  WIDTH  to ALU a
alu_b  output  WIDTH  to ALU b
alu_operation  output  4  to ALU operation
alu_result  input  WIDTH  from ALU result
alu_carry_out  input  1  from ALU carry_out
rsp_valid  output  1  response register holds a result
rsp_ready  input  1  consumer takes response
rsp_result  output  WIDTH  registered result
rsp_carry_out  output  1  registered carry
acc  output  WIDTH  current accumulator value
fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous): FIFO emptied and contents discarded, fifo_count=0, rsp_valid=0, rsp_result=0, rsp_carry_out=0, acc=0. Reset mid-operation drops in-flight commands with no response. cmd_ready=1 once reset is released.
- cmd_ready = (fifo_count < DEPTH). It does not account for a same-cycle pop, so a full FIFO never accepts.
- Push: cmd_valid && cmd_ready at the edge stores {cmd_a, cmd_b, cmd_op, cmd_use_acc} at the tail.
- Head drive (combinational):
  - When fifo_count > 0: alu_a = head.use_acc ? acc : head.a; alu_b = head.b; alu_operation = head.op.
  - When empty: all alu_* = 0.
- Issue condition: fifo_count > 0 && (!rsp_valid || rsp_ready). On issue at an edge:
  - pop head;
  - rsp_result <= alu_result; rsp_carry_out <= alu_carry_out; rsp_valid <= 1;
  - acc <= alu_result.
- No issue and rsp_valid && rsp_ready: rsp_valid <= 0.
- While rsp_valid && !rsp_ready: rsp_result and rsp_carry_out hold stable and no issue occurs.
- Throughput: one result per cycle when rsp_ready is held high.
- Latency: command pushed at edge E into an empty FIFO with a free response register gives rsp_valid=1 after edge E+1.
- Simultaneous push and pop: fifo_count unchanged, ordering preserved (strict FIFO).
- acc_clear:
  - Sets acc to 0 at the edge and has priority over the issue update.
  - A command issued in the same cycle uses the pre-clear acc; its response is still produced normally.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH and never over/underflows.
- Arithmetic is entirely the ALU's. This block performs no width extension or carry modification.

Test Plan:
- Reset then push a=0x33 b=0xCC op=0000 (add), rsp_ready=1 -> alu_a=0x33, alu_b=0xCC driven; after the next edge rsp_valid=1, rsp_result=0xFF, rsp_carry_out=0, acc=0xFF.
- Chain: push (0xFF, 0x01, add), then (use_acc=1, b=0x05, add) -> responses 0x00/carry 1, then 0x05/carry 0; alu_a for the second command equals 0x00.
- Backpressure: rsp_ready=0, push 5 commands back-to-back -> cmd_ready drops after 4 accepted plus 1 issued (fifo_count=4, rsp_valid=1 holding the first result stable). Raise rsp_ready -> 5 responses in order, one per cycle.
- acc_clear asserted in the same cycle a use_acc command issues with acc=0x10, b=0x01 add -> rsp_result=0x11, acc=0x00 afterwards.
- Assert rst_n=0 asynchronously with 3 queued commands and rsp_valid=1 -> rsp_valid, fifo_count and acc go to 0 immediately. No stale responses appear after release.
- Random ops/operands for 1000 cycles with random rsp_ready, checked against a reference ALU model and scoreboard -> all responses in order with exact result/carry, no drops or duplicates.
